// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: one-hot states,
// coin values, goods limits and the unit price helper.
package vend_pkg;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_SELECT  = 6'b000010,
    ST_CONFIRM = 6'b000100,
    ST_PAY     = 6'b001000,
    ST_DONE    = 6'b010000,
    ST_REFUND  = 6'b100000
  } state_e;

  localparam logic [7:0] COIN_1_VAL  = 8'd1;
  localparam logic [7:0] COIN_5_VAL  = 8'd5;
  localparam logic [7:0] COIN_10_VAL = 8'd10;

  localparam logic [2:0] GOODS_MIN = 3'd1;
  localparam logic [2:0] GOODS_MAX = 3'd4;
  localparam logic [1:0] NUM_MIN   = 2'd1;
  localparam logic [1:0] NUM_MAX   = 2'd3;

  function automatic logic [3:0] price(input logic [2:0] high, input logic [2:0] low);
    return {1'b0, high} + {1'b0, low};
  endfunction

  function automatic logic sel_valid(input logic [2:0] high, input logic [2:0] low,
                                     input logic [1:0] num);
    return (high >= GOODS_MIN) && (high <= GOODS_MAX) &&
           (low >= GOODS_MIN) && (low <= GOODS_MAX) &&
           (num >= NUM_MIN) && (num <= NUM_MAX);
  endfunction

endpackage

// File: rtl/vend_if.sv
// Key/coin/switch inputs and display-side outputs of the vending controller.
interface vend_if;
  logic       key_confirm;
  logic       key_cancel;
  logic       coin_1;
  logic       coin_5;
  logic       coin_10;
  logic [2:0] sw_goods_high;
  logic [2:0] sw_goods_low;
  logic [1:0] sw_goods_num;
  logic [5:0] state;
  logic [2:0] goods_high;
  logic [2:0] goods_low;
  logic [1:0] goods_num;
  logic [6:0] need_money;
  logic [7:0] input_money;
  logic [7:0] change_money;

  modport master (
    output key_confirm, key_cancel, coin_1, coin_5, coin_10,
           sw_goods_high, sw_goods_low, sw_goods_num,
    input  state, goods_high, goods_low, goods_num,
           need_money, input_money, change_money
  );

  modport slave (
    input  key_confirm, key_cancel, coin_1, coin_5, coin_10,
           sw_goods_high, sw_goods_low, sw_goods_num,
    output state, goods_high, goods_low, goods_num,
           need_money, input_money, change_money
  );
endinterface

// File: rtl/vend_timer.sv
// 32-bit loadable down-counter; expired_o flags the cycle whose edge brings it
// to zero, so expiry lands exactly load_value edges after the load edge.
module vend_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_value_i,
  output logic        expired_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: reload wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      cnt_d = 32'd0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 32'd1) && !load_i;

endmodule

// File: rtl/vend_controller.sv
// Vending state machine: goods selection, payment with timeout, and a held
// DONE/REFUND result; every display output comes straight from a flop.
module vend_controller
  import vend_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000_000,
  parameter logic [31:0] HOLD_CYCLES    = 32'd300_000_000
) (
  input logic   sys_clk,
  input logic   sys_rst,
  vend_if.slave bus
);

  state_e     state_q, state_d;
  logic [2:0] high_q, high_d, low_q, low_d;
  logic [1:0] num_q, num_d;
  logic [6:0] need_q, need_d;
  logic [7:0] in_q, in_d, chg_q, chg_d;

  logic       load_to_s, load_hold_s, to_expired_s, hold_expired_s;
  logic       coin_any_s;
  logic [7:0] sum_s;

  assign coin_any_s = bus.coin_1 || bus.coin_5 || bus.coin_10;
  assign sum_s = in_q + (bus.coin_1  ? COIN_1_VAL  : 8'd0)
                      + (bus.coin_5  ? COIN_5_VAL  : 8'd0)
                      + (bus.coin_10 ? COIN_10_VAL : 8'd0);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    high_d      = high_q;
    low_d       = low_q;
    num_d       = num_q;
    need_d      = need_q;
    in_d        = in_q;
    chg_d       = chg_q;
    load_to_s   = 1'b0;
    load_hold_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_confirm) state_d = ST_SELECT;
        else                 state_d = ST_IDLE;
      end
      ST_SELECT: begin
        if (bus.key_cancel) begin
          state_d = ST_IDLE;
          high_d  = 3'd0;
          low_d   = 3'd0;
          num_d   = 2'd0;
        end else begin
          high_d = bus.sw_goods_high;
          low_d  = bus.sw_goods_low;
          num_d  = bus.sw_goods_num;
          if (bus.key_confirm &&
              sel_valid(bus.sw_goods_high, bus.sw_goods_low, bus.sw_goods_num))
            state_d = ST_CONFIRM;
          else
            state_d = ST_SELECT;
        end
      end
      ST_CONFIRM: begin
        if (bus.key_cancel) begin
          state_d = ST_SELECT;
        end else if (bus.key_confirm) begin
          state_d   = ST_PAY;
          need_d    = {3'd0, price(high_q, low_q)} * {5'd0, num_q};
          load_to_s = 1'b1;
        end else begin
          state_d = ST_CONFIRM;
        end
      end
      ST_PAY: begin
        // Cancel outranks a completing coin; a coin outranks a same-cycle timeout.
        if (bus.key_cancel) begin
          state_d     = ST_REFUND;
          in_d        = sum_s;
          chg_d       = sum_s;
          load_hold_s = 1'b1;
        end else if (sum_s >= {1'b0, need_q}) begin
          state_d     = ST_DONE;
          in_d        = sum_s;
          chg_d       = sum_s - {1'b0, need_q};
          load_hold_s = 1'b1;
        end else if (coin_any_s) begin
          in_d      = sum_s;
          load_to_s = 1'b1;
        end else if (to_expired_s) begin
          state_d     = ST_REFUND;
          chg_d       = in_q;
          load_hold_s = 1'b1;
        end else begin
          state_d = ST_PAY;
        end
      end
      ST_DONE, ST_REFUND: begin
        if (hold_expired_s) begin
          state_d = ST_IDLE;
          high_d  = 3'd0;
          low_d   = 3'd0;
          num_d   = 2'd0;
          need_d  = 7'd0;
          in_d    = 8'd0;
          chg_d   = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        high_d  = 3'd0;
        low_d   = 3'd0;
        num_d   = 2'd0;
        need_d  = 7'd0;
        in_d    = 8'd0;
        chg_d   = 8'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      high_q  <= 3'd0;
      low_q   <= 3'd0;
      num_q   <= 2'd0;
      need_q  <= 7'd0;
      in_q    <= 8'd0;
      chg_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      num_q   <= num_d;
      need_q  <= need_d;
      in_q    <= in_d;
      chg_q   <= chg_d;
    end
  end

  vend_timer u_timeout (
    .clk_i        (sys_clk),
    .rst_i        (sys_rst),
    .load_i       (load_to_s),
    .load_value_i (TIMEOUT_CYCLES),
    .expired_o    (to_expired_s)
  );

  vend_timer u_hold (
    .clk_i        (sys_clk),
    .rst_i        (sys_rst),
    .load_i       (load_hold_s),
    .load_value_i (HOLD_CYCLES),
    .expired_o    (hold_expired_s)
  );

  assign bus.state        = state_q;
  assign bus.goods_high   = high_q;
  assign bus.goods_low    = low_q;
  assign bus.goods_num    = num_q;
  assign bus.need_money   = need_q;
  assign bus.input_money  = in_q;
  assign bus.change_money = chg_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios then biased random stimulus,
// every cycle compared against a behavioural model of the vending rules.
module tb_vend_controller;

  localparam int TO_CYC   = 100;
  localparam int HOLD_CYC = 20;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  vend_if bus ();

  vend_controller #(
    .TIMEOUT_CYCLES (32'd100),
    .HOLD_CYCLES    (32'd20)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase index 0..5 = idle/select/confirm/pay/done/refund,
  // plus elapsed-cycle counters for the pay wait and result hold.
  int m_ph, m_gh, m_gl, m_gn, m_need, m_in, m_chg, m_wait, m_hold;
  int sw_h, sw_l, sw_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ph = 0; m_gh = 0; m_gl = 0; m_gn = 0;
    m_need = 0; m_in = 0; m_chg = 0; m_wait = 0; m_hold = 0;
  endtask

  task automatic model_step(input int rst, input int cf, input int cn,
                            input int c1, input int c5, input int c10);
    int coins, total;
    bit ok;
    coins = c1 + 5 * c5 + 10 * c10;
    total = m_in + coins;
    ok = (sw_h >= 1 && sw_h <= 4 && sw_l >= 1 && sw_l <= 4 && sw_n >= 1 && sw_n <= 3);
    if (rst != 0) begin
      model_clear();
    end else begin
      case (m_ph)
        0: if (cf != 0) m_ph = 1;
        1: begin
          if (cn != 0) begin
            m_ph = 0; m_gh = 0; m_gl = 0; m_gn = 0;
          end else begin
            m_gh = sw_h; m_gl = sw_l; m_gn = sw_n;
            if (cf != 0 && ok) m_ph = 2;
          end
        end
        2: begin
          if (cn != 0) m_ph = 1;
          else if (cf != 0) begin
            m_ph = 3; m_need = (m_gh + m_gl) * m_gn; m_wait = 0;
          end
        end
        3: begin
          if (cn != 0) begin
            m_ph = 5; m_in = total; m_chg = total; m_hold = 0;
          end else if (total >= m_need) begin
            m_ph = 4; m_in = total; m_chg = total - m_need; m_hold = 0;
          end else if (coins != 0) begin
            m_in = total; m_wait = 0;
          end else begin
            m_wait++;
            if (m_wait == TO_CYC) begin
              m_ph = 5; m_chg = m_in; m_hold = 0;
            end
          end
        end
        default: begin
          m_hold++;
          if (m_hold == HOLD_CYC) model_clear();
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("state", bus.state, 32'd1 << m_ph);
    check_eq("goods_high", bus.goods_high, m_gh);
    check_eq("goods_low", bus.goods_low, m_gl);
    check_eq("goods_num", bus.goods_num, m_gn);
    check_eq("need_money", bus.need_money, m_need);
    check_eq("input_money", bus.input_money, m_in);
    check_eq("change_money", bus.change_money, m_chg);
  endtask

  task automatic cycle(input int rst, input int cf, input int cn,
                       input int c1, input int c5, input int c10);
    sys_rst           = (rst != 0);
    bus.key_confirm   = (cf != 0);
    bus.key_cancel    = (cn != 0);
    bus.coin_1        = (c1 != 0);
    bus.coin_5        = (c5 != 0);
    bus.coin_10       = (c10 != 0);
    bus.sw_goods_high = 3'(sw_h);
    bus.sw_goods_low  = 3'(sw_l);
    bus.sw_goods_num  = 2'(sw_n);
    model_step(rst, cf, cn, c1, c5, c10);
    @(posedge sys_clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic to_pay(input int h, input int l, input int n);
    sw_h = h; sw_l = l; sw_n = n;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    sw_h = 0; sw_l = 0; sw_n = 0;

    // Reset
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("rst_state", bus.state, 32'h01);
    check_eq("rst_change", bus.change_money, 32'd0);

    // Normal purchase 2/3/2
    to_pay(2, 3, 2);
    check_eq("pay_state", bus.state, 32'h08);
    check_eq("need_10", bus.need_money, 32'd10);
    cycle(0, 0, 0, 0, 1, 0);
    check_eq("in_5", bus.input_money, 32'd5);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("done_state", bus.state, 32'h10);
    check_eq("done_in", bus.input_money, 32'd15);
    check_eq("done_chg", bus.change_money, 32'd5);
    idle(HOLD_CYC - 1);
    check_eq("hold_not_yet", bus.state, 32'h10);
    idle(1);
    check_eq("hold_idle", bus.state, 32'h01);
    check_eq("hold_in_clr", bus.input_money, 32'd0);

    // Invalid selections
    cycle(0, 1, 0, 0, 0, 0);
    sw_h = 5; sw_l = 2; sw_n = 1;
    cycle(0, 1, 0, 0, 0, 0);
    check_eq("bad_high", bus.state, 32'h02);
    sw_h = 2; sw_n = 0;
    cycle(0, 1, 0, 0, 0, 0);
    check_eq("bad_num", bus.state, 32'h02);
    sw_h = 1; sw_l = 1; sw_n = 1;
    cycle(0, 1, 0, 0, 0, 0);
    check_eq("good_sel", bus.state, 32'h04);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    check_eq("cancel_wins", bus.state, 32'h01);

    // Cancel with same-cycle coin
    to_pay(4, 4, 1);
    check_eq("need_8", bus.need_money, 32'd8);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 1, 0);
    check_eq("refund_state", bus.state, 32'h20);
    check_eq("refund_in", bus.input_money, 32'd6);
    check_eq("refund_chg", bus.change_money, 32'd6);
    idle(HOLD_CYC);

    // Timeout reloaded by a coin
    to_pay(1, 1, 1);
    idle(49);
    cycle(0, 0, 0, 1, 0, 0);
    idle(50);
    check_eq("no_early_to", bus.state, 32'h08);
    idle(49);
    check_eq("to_edge_minus1", bus.state, 32'h08);
    idle(1);
    check_eq("to_refund", bus.state, 32'h20);
    check_eq("to_chg", bus.change_money, 32'd1);
    idle(HOLD_CYC);

    // Reset mid-payment, coins in IDLE ignored
    to_pay(4, 4, 2);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check_eq("in_7", bus.input_money, 32'd7);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("mid_rst_state", bus.state, 32'h01);
    check_eq("mid_rst_in", bus.input_money, 32'd0);
    cycle(0, 0, 0, 1, 1, 1);
    check_eq("idle_coin", bus.input_money, 32'd0);

    // Biased random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        sw_h = (($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4)));
        sw_l = (($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4)));
        sw_n = (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)));
      end
      cycle(($urandom_range(0, 999) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            ($urandom_range(0, 59) == 0) ? 1 : 0,
            ($urandom_range(0, 29) == 0) ? 1 : 0,
            ($urandom_range(0, 49) == 0) ? 1 : 0,
            ($urandom_range(0, 79) == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
